// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite-path constants (default sizes), requester index type and 12-bit RGB word type
package sprite_pkg;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 12;
  typedef logic [$clog2(DEF_N_REQ)-1:0] req_idx_t;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; req/ptr in, one-hot + index + any out (first req at or above ptr, wrapping)
module rr_pick import sprite_pkg::*; #(
  parameter int N = DEF_N_REQ,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] c;
  always_comb begin
    any = 1'b0;
    idx = '0;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = IW'((int'(ptr) + i) % N);
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
    onehot = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin/burst-lock arbiter sharing one sprite ROM port; req/lock/addr_in -> gnt, rom_addr/rom_rd -> ROM, rom_data -> rd_valid/rd_data, busy
module sprite_rom_arbiter import sprite_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROM_LAT = 2,
  parameter int MAX_BURST = 8,
  localparam int IW = $clog2(N_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_rd,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    busy
);
  logic [IW-1:0] rr_ptr, owner, pick_idx, win, iss_tag;
  logic owner_v, pick_any, hold;
  logic [N_REQ-1:0] pick_oh;
  logic [BW-1:0] burst_cnt;
  logic [ADDR_W-1:0] win_addr;
  logic [ROM_LAT-1:0] tag_v;
  logic [IW-1:0] tag [ROM_LAT];
  rr_pick #(.N(N_REQ)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .onehot(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign hold = owner_v && req[owner] && lock[owner] && burst_cnt < BW'(MAX_BURST);
  assign win = hold ? owner : pick_idx;
  assign gnt = Reset ? '0 : hold ? N_REQ'(1) << owner : pick_oh;
  assign busy = rom_rd || |tag_v;
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win == IW'(i)) win_addr = addr_in[i*ADDR_W +: ADDR_W];
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr <= '0;
      owner <= '0;
      owner_v <= 1'b0;
      burst_cnt <= '0;
      rom_rd <= 1'b0;
      rom_addr <= '0;
      iss_tag <= '0;
      tag_v <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag[i] <= '0;
      rd_valid <= '0;
      rd_data <= '0;
    end else begin
      rom_rd <= |gnt;
      if (|gnt) begin
        rom_addr <= win_addr;
        iss_tag <= win;
        rr_ptr <= win == IW'(N_REQ - 1) ? '0 : win + 1'b1;
      end
      owner_v <= |gnt;
      owner <= win;
      burst_cnt <= hold ? burst_cnt + 1'b1 : pick_any ? BW'(1) : '0;
      for (int i = ROM_LAT - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag[i] <= tag[i-1];
      end
      tag_v[0] <= rom_rd;
      tag[0] <= iss_tag;
      rd_valid <= tag_v[ROM_LAT-1] ? N_REQ'(1) << tag[ROM_LAT-1] : '0;
      if (tag_v[ROM_LAT-1]) rd_data <= rom_data;
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed stimulus with a queue-style behavioural model checked every cycle plus literal spot checks
module tb_sprite_rom_arbiter;
  localparam int N = 4;
  localparam int AW = 15;
  localparam int DW = 12;
  localparam int MAXB = 8;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [N*AW-1:0] addr_in = '0;
  logic [N-1:0] gnt, rd_valid;
  logic [AW-1:0] rom_addr, p1;
  logic rom_rd, busy;
  logic [DW-1:0] rom_data, rd_data;
  int pass_cnt = 0;
  int total = 0;
  sprite_rom_arbiter dut (
    .Clk(Clk),
    .Reset(Reset),
    .req(req),
    .lock(lock),
    .addr_in(addr_in),
    .gnt(gnt),
    .rom_addr(rom_addr),
    .rom_rd(rom_rd),
    .rom_data(rom_data),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .busy(busy)
  );
  always #5 Clk = ~Clk;
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return DW'(32'(a) * 5 + 32'h3A5);
  endfunction
  always @(posedge Clk) begin
    p1 <= rom_addr;
    rom_data <= rom_f(p1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask
  int m_ptr = 0;
  int m_owner = -1;
  int m_cnt = 0;
  int w;
  bit hv [1:4];
  int hi [1:4];
  logic [AW-1:0] ha [1:4];
  bit armed = 1'b0;
  initial forever begin
    @(negedge Clk);
    w = -1;
    if (Reset) begin
      m_ptr = 0;
      m_owner = -1;
      m_cnt = 0;
    end else begin
      if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_cnt < MAXB) begin
        w = m_owner;
        m_cnt++;
      end else begin
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_owner = w;
        m_cnt = w >= 0 ? 1 : 0;
      end
      if (w >= 0) m_ptr = (w + 1) % N;
    end
    if (armed) begin
      chk("m_gnt", gnt, w >= 0 ? 32'(1) << w : 32'd0);
      chk("m_rom_rd", rom_rd, 32'(hv[1]));
      if (hv[1]) chk("m_rom_addr", rom_addr, ha[1]);
      chk("m_rd_valid", rd_valid, hv[4] ? 32'(1) << hi[4] : 32'd0);
      if (hv[4]) chk("m_rd_data", rd_data, rom_f(ha[4]));
      chk("m_busy", busy, 32'(hv[1] | hv[2] | hv[3]));
    end
    for (int k = 4; k > 1; k--) begin
      hv[k] = hv[k-1];
      hi[k] = hi[k-1];
      ha[k] = ha[k-1];
    end
    hv[1] = w >= 0;
    hi[1] = w;
    ha[1] = w >= 0 ? addr_in[w*AW +: AW] : '0;
    if (Reset) for (int k = 1; k <= 4; k++) hv[k] = 1'b0;
    armed = 1'b1;
  end
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr_in[i*AW +: AW] = a;
  endtask
  task automatic do_reset;
    Reset = 1'b1;
    req = '0;
    lock = '0;
    tick;
    tick;
    Reset = 1'b0;
  endtask
  initial begin
    repeat (3) tick;
    Reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_rom_rd", rom_rd, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_busy", busy, 0);
      if (k == 0) begin
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rom_addr", rom_addr, 0);
      end
    end
    tick;
    set_addr(0, 15'h0123);
    set_addr(1, 15'h7FFF);
    req = 4'b0001;
    @(negedge Clk);
    chk("single_gnt", gnt, 4'b0001);
    tick;
    req = '0;
    @(negedge Clk);
    chk("single_rom_rd", rom_rd, 1);
    chk("single_rom_addr", rom_addr, 15'h0123);
    repeat (3) tick;
    @(negedge Clk);
    chk("single_rd_valid", rd_valid, 4'b0001);
    chk("single_rd_data", rd_data, 12'h954);
    do_reset;
    for (int i = 0; i < N; i++) set_addr(i, AW'(15'h1000 + i * 15'h0111));
    req = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      chk("rr_gnt", gnt, 1 << (k % 4));
      if (k >= 4) chk("rr_rd_valid", rd_valid, 1 << (k % 4));
      tick;
    end
    req = '0;
    repeat (5) tick;
    do_reset;
    req = 4'b0011;
    lock = 4'b0001;
    for (int k = 0; k < 18; k++) begin
      @(negedge Clk);
      chk("burst_gnt", gnt, (k == 8 || k == 17) ? 2 : 1);
      tick;
    end
    req = '0;
    lock = '0;
    repeat (5) tick;
    do_reset;
    req = 4'b0001;
    lock = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      chk("solo_burst_gnt", gnt, 1);
      tick;
    end
    req = '0;
    lock = '0;
    repeat (5) tick;
    do_reset;
    req = 4'b0111;
    repeat (3) tick;
    req = '0;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      chk("midrst_rd_valid", rd_valid, 0);
      chk("midrst_busy", busy, 0);
      tick;
    end
    do_reset;
    req = 4'b0011;
    @(negedge Clk);
    chk("drop_gnt0", gnt, 4'b0001);
    tick;
    req = 4'b1010;
    @(negedge Clk);
    chk("drop_gnt1", gnt, 4'b0010);
    tick;
    req = '0;
    tick;
    tick;
    @(negedge Clk);
    chk("drop_rv0", rd_valid, 4'b0001);
    tick;
    @(negedge Clk);
    chk("drop_rv1", rd_valid, 4'b0010);
    repeat (4) tick;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
